// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the data-memory access path.
// Size codes, FSM states, big-endian lane shift/mask/extract/extend.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RSP
  } state_t;

  // Big-endian: lane 0 is the MSB byte, so shift = (3-lane)*8.
  function automatic logic [4:0] lane_shift(
    input logic [1:0] size,
    input logic [1:0] lane
  );
    case (size)
      SIZE_BYTE: lane_shift = {~lane, 3'b000};
      SIZE_HALF: lane_shift = {~lane[1], 4'b0000};
      default:   lane_shift = 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] lane
  );
    logic [31:0] m;
    case (size)
      SIZE_BYTE: m = 32'h0000_00ff;
      SIZE_HALF: m = 32'h0000_ffff;
      default:   m = 32'hffff_ffff;
    endcase
    lane_mask = m << lane_shift(size, lane);
  endfunction

  function automatic logic [31:0] lane_extract(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  lane
  );
    logic [31:0] s;
    s = word >> lane_shift(size, lane);
    case (size)
      SIZE_BYTE: lane_extract = {24'd0, s[7:0]};
      SIZE_HALF: lane_extract = {16'd0, s[15:0]};
      default:   lane_extract = s;
    endcase
  endfunction

  function automatic logic [31:0] sign_ext(
    input logic [31:0] v,
    input logic [1:0]  size,
    input logic        uns
  );
    case (size)
      SIZE_BYTE: sign_ext = uns ? v : {{24{v[7]}}, v[7:0]};
      SIZE_HALF: sign_ext = uns ? v : {{16{v[15]}}, v[15:0]};
      default:   sign_ext = v;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus data-memory port bundle.
// slave: the access unit; master: requester and memory side.
interface mem_access_unit_if #(
  parameter int MEM_ADDR_BITS = 6
);
  logic                     i_req_valid;
  logic                     o_req_ready;
  logic                     i_req_we;
  logic [1:0]               i_req_size;
  logic                     i_req_unsigned;
  logic [31:0]              i_req_addr;
  logic [31:0]              i_req_wdata;
  logic                     o_rsp_valid;
  logic                     i_rsp_ready;
  logic [31:0]              o_rsp_rdata;
  logic                     o_rsp_err;
  logic [MEM_ADDR_BITS-1:0] o_mem_addr;
  logic                     o_mem_wr_en;
  logic [31:0]              o_mem_wdata;
  logic [31:0]              i_mem_rdata;

  modport slave (
    input  i_req_valid, i_req_we, i_req_size,
    input  i_req_unsigned, i_req_addr, i_req_wdata,
    input  i_rsp_ready, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata,
    output o_rsp_err, o_mem_addr, o_mem_wr_en,
    output o_mem_wdata
  );

  modport master (
    output i_req_valid, i_req_we, i_req_size,
    output i_req_unsigned, i_req_addr, i_req_wdata,
    output i_rsp_ready, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata,
    input  o_rsp_err, o_mem_addr, o_mem_wr_en,
    input  o_mem_wdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane merge (store) and lane extract/extend (load).
// Ports: i_old_word, i_new_data, i_size, i_lane, i_unsigned -> o_store_word, o_load_word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_new_data,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_unsigned,
  output logic [31:0] o_store_word,
  output logic [31:0] o_load_word
);
  logic [4:0]  w_sh;
  logic [31:0] w_mask;

  assign w_sh   = lane_shift(i_size, i_lane);
  assign w_mask = lane_mask(i_size, i_lane);

  assign o_store_word = (i_old_word & ~w_mask)
                      | ((i_new_data << w_sh) & w_mask);

  assign o_load_word = sign_ext(
    lane_extract(i_old_word, i_size, i_lane),
    i_size, i_unsigned);
endmodule

// File: rtl/mem_access_unit.sv
// Big-endian data-memory initiator: loads, word stores, sub-word RMW stores.
// Ports: clk, rst (sync active-low), bus (slave modport: req/rsp/mem port).
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_BYTES     = 64,
  parameter int MEM_ADDR_BITS = $clog2(MEM_BYTES)
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.slave   bus
);
  state_t r_state, w_next;

  logic                     r_we;
  logic [1:0]               r_size;
  logic                     r_uns;
  logic [1:0]               r_lane;
  logic [31:0]              r_wdata;
  logic                     r_err;
  logic [31:0]              r_rdata;
  logic [MEM_ADDR_BITS-1:0] r_mem_addr;
  logic [31:0]              r_mem_wdata;

  logic        w_err;
  logic        w_word_st;
  logic        w_ready;
  logic        w_rsp_valid;
  logic [31:0] w_merged;
  logic [31:0] w_load;

  assign w_err =
    (bus.i_req_size == 2'b11) ||
    (bus.i_req_size == SIZE_HALF && bus.i_req_addr[0]) ||
    (bus.i_req_size == SIZE_WORD && bus.i_req_addr[1:0] != 2'b00) ||
    (|(bus.i_req_addr >> MEM_ADDR_BITS));

  assign w_word_st = bus.i_req_we && bus.i_req_size == SIZE_WORD;

  mem_lane_align u_align (
    .i_old_word   (bus.i_mem_rdata),
    .i_new_data   (r_wdata),
    .i_size       (r_size),
    .i_lane       (r_lane),
    .i_unsigned   (r_uns),
    .o_store_word (w_merged),
    .o_load_word  (w_load)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_rsp_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.i_req_valid) begin
          if (w_err)          w_next = RSP;
          else if (w_word_st) w_next = WR;
          else                w_next = RD;
        end
      end
      RD:  w_next = r_we ? WR : RSP;
      WR:  w_next = RSP;
      RSP: begin
        w_rsp_valid = 1'b1;
        if (bus.i_rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_uns       <= 1'b0;
      r_lane      <= 2'b00;
      r_wdata     <= 32'd0;
      r_err       <= 1'b0;
      r_rdata     <= 32'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.i_req_valid) begin
            r_we    <= bus.i_req_we;
            r_size  <= bus.i_req_size;
            r_uns   <= bus.i_req_unsigned;
            r_lane  <= bus.i_req_addr[1:0];
            r_wdata <= bus.i_req_wdata;
            r_err   <= w_err;
            r_rdata <= 32'd0;
            if (!w_err) begin
              r_mem_addr <= {bus.i_req_addr[MEM_ADDR_BITS-1:2], 2'b00};
              if (w_word_st) r_mem_wdata <= bus.i_req_wdata;
            end
          end
        end
        // Old word arrives here: either the load result or RMW merge source.
        RD: begin
          if (r_we) r_mem_wdata <= w_merged;
          else      r_rdata     <= w_load;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_req_ready = w_ready;
  assign bus.o_rsp_valid = w_rsp_valid;
  assign bus.o_rsp_rdata = r_rdata;
  assign bus.o_rsp_err   = r_err;
  assign bus.o_mem_addr  = r_mem_addr;
  assign bus.o_mem_wdata = r_mem_wdata;
  // Reset gates the strobe immediately so an abandoned WR never writes.
  assign bus.o_mem_wr_en = rst && (r_state == WR);
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the byte-addressed, big-endian, 32-bit data memory. It sits between the MIPS MEM pipeline stage and the data memory.
- Accepts load/store requests of byte, halfword or word size. Word-aligns the address and drives the memory's single addr/wr_en/data port.
- Loads: extracts and sign/zero-extends the addressed lane. Sub-word stores: performed as read-modify-write.
- Flags misaligned and out-of-range requests without touching memory.

Parameters:
- MEM_BYTES, 64, memory capacity in bytes; must match the attached memory.
- MEM_ADDR_BITS, $clog2(MEM_BYTES), width of the memory address bus.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low
- i_req_valid  in  1  request present
- o_req_ready  out  1  unit can accept a request
- i_req_we  in  1  1=store, 0=load
- i_req_size  in  2  00=byte, 01=half, 10=word; 11 is illegal and flagged as error
- i_req_unsigned  in  1  zero-extend loads when 1
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, right-justified
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  consumer takes response
- o_rsp_rdata  out  32  load result; 0 for stores and errors
- o_rsp_err  out  1  misaligned, out-of-range or illegal size
- o_mem_addr  out  MEM_ADDR_BITS  word-aligned byte address
- o_mem_wr_en  out  1  memory write enable
- o_mem_wdata  out  32  memory write data
- i_mem_rdata  in  32  memory read data, combinational from o_mem_addr when o_mem_wr_en=0

Behaviour:
- Reset: while rst=0 at a clock edge, the unit goes to IDLE and clears all captured registers.
  - o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0, o_mem_addr=0, o_mem_wdata=0.
  - o_mem_wr_en is forced 0 combinationally whenever rst=0.
- FSM states: IDLE, RD, WR, RSP.
- o_req_ready=1 only in IDLE. A request is accepted when i_req_valid & o_req_ready at a rising edge; address, size, data and flags are captured at that edge.
- Lane numbering (big-endian): lane = addr[1:0].
  - Lane 0 = bits 31:24, lane 3 = bits 7:0.
  - Halfword at addr[1]=0 = bits 31:16; at addr[1]=1 = bits 15:0.
- Error check at accept; error → next state RSP with o_rsp_err=1 and no memory access. Error conditions:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - size=11;
  - aligned address > MEM_BYTES-4, i.e. any of addr[31:MEM_ADDR_BITS] nonzero.
- Load: IDLE → RD → RSP.
  - In RD: o_mem_addr = {addr[MEM_ADDR_BITS-1:2],2'b00}, wr_en=0; i_mem_rdata captured at the end of RD.
  - Latency: o_rsp_valid rises 2 cycles after accept.
- Word store: IDLE → WR → RSP.
  - In WR: wr_en=1 for exactly one cycle; wdata = i_req_wdata.
- Byte/half store: IDLE → RD → WR → RSP.
  - RD captures the old word.
  - WR writes the old word with the addressed lane replaced by wdata[7:0] or wdata[15:0].
  - The other lanes must be bit-identical to the old word.
- Memory port stability: o_mem_addr and o_mem_wdata are registered and stable for the whole RD/WR cycle. wr_en is never asserted outside WR.
- RSP: o_rsp_valid=1 and outputs are held until i_rsp_ready=1 at an edge, then IDLE. A new request can be accepted on the next cycle; there is no same-cycle RSP→accept.
- Load extension:
  - Signed byte/half replicate bit 7/15.
  - Unsigned zero-fills.
  - Word passes through.
- Reset mid-operation (any state): abandon the request, no write is issued afterwards, no response is produced; IDLE on the following cycle.
- i_req_valid while busy: ignored (ready=0); the requester must hold it.

Decomposition:
- Shared package mem_pkg:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - FSM state encoding;
  - lane-extract and sign-extend functions.
- One combinational sub-module, mem_lane_align: given old word, new data, size and lane, produce the merged store word and the extended load value. It is reused by the future cache path.

Test Plan:
- Memory word 0x08 = 0x11223344; LW 0x08 → o_rsp_rdata=0x11223344, err=0; o_rsp_valid exactly 2 cycles after accept; wr_en never high.
- Word 0x0C = 0x80FF7F01:
  - LB 0x0C → 0xFFFFFF80;
  - LBU 0x0C → 0x00000080;
  - LH 0x0E → 0x00007F01;
  - LH 0x0C → 0xFFFF80FF.
- SB 0x09 with wdata 0x000000AB on word 0x11223344 → one RD cycle then one WR cycle at addr 0x08 with wdata 0x11AB3344; readback LW 0x08 = 0x11AB3344.
- LW 0x06 and SH 0x03 and size=11 → o_rsp_err=1 one cycle after accept; o_mem_wr_en stays 0; rdata=0.
- SW 0x40 with MEM_BYTES=64 → err=1, no write; SW 0x3C 0xDEADBEEF → written, readback OK.
- Hold i_rsp_ready=0 for 3 cycles → response held stable, ready=0. Separately, rst=0 during RD of an SB → no wr_en pulse, o_rsp_valid stays 0, ready=1 after reset release, memory unchanged.
